// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared types and constants for the BCD stopwatch counter.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned COUNT_W    = NUM_DIGITS * DIGIT_W;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Saturate every nibble above 9 down to 9 so preset values stay valid BCD.
  function automatic logic [COUNT_W-1:0] clamp_bcd(input logic [COUNT_W-1:0] value);
    logic [COUNT_W-1:0] result;
    bcd_digit_t         digit;
    result = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit = value[i*DIGIT_W +: DIGIT_W];
      result[i*DIGIT_W +: DIGIT_W] = (digit > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_if.sv
// Button/switch controls into the stopwatch and display value out of it.
interface bcd_stopwatch_counter_if;
  import bcd_stopwatch_pkg::*;

  logic               start_stop;
  logic               clear;
  logic               lap;
  logic               load;
  logic [COUNT_W-1:0] load_value;
  logic [COUNT_W-1:0] bcd_out;
  logic               running;
  logic               overflow;

  modport master (
    output start_stop, clear, lap, load, load_value,
    input  bcd_out, running, overflow
  );

  modport slave (
    input  start_stop, clear, lap, load, load_value,
    output bcd_out, running, overflow
  );

endinterface

// File: rtl/bcd_stopwatch_counter_incrementer.sv
// Combinational packed-BCD add-one with ripple carry across digits.
module bcd_incrementer
  import bcd_stopwatch_pkg::*;
(
  input  logic [COUNT_W-1:0] bcd_in,
  output logic [COUNT_W-1:0] sum_c,
  output logic               wrap_c
);

  logic       carry;
  bcd_digit_t digit;

  // Walk digits from least significant, turning 9s into 0s while the carry lives.
  always_comb begin
    sum_c = bcd_in;
    carry = 1'b1;
    digit = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit = bcd_in[i*DIGIT_W +: DIGIT_W];
      if (carry) begin
        if (digit >= BCD_MAX_DIGIT) begin
          sum_c[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          sum_c[i*DIGIT_W +: DIGIT_W] = bcd_digit_t'(digit + 4'd1);
          carry = 1'b0;
        end
      end
    end
    wrap_c = carry;
  end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Stopwatch producing an 8-digit packed BCD count for the 7-segment display.
module bcd_stopwatch_counter
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_stopwatch_counter_if.slave   sw
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  sw_state_t          state, state_nxt;
  logic [COUNT_W-1:0] count, count_nxt;
  logic [COUNT_W-1:0] snapshot, snapshot_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic               lap_hold, lap_hold_nxt;
  logic               overflow_nxt;

  logic ss_prev, clr_prev, lap_prev, load_prev;
  logic ss_ev_c, clr_ev_c, lap_ev_c, load_ev_c;
  logic tick_c;

  logic [COUNT_W-1:0] inc_c;
  logic               wrap_c;

  // Rising-edge events; prev regs reset high so a held button is not an event.
  assign ss_ev_c   = sw.start_stop & ~ss_prev;
  assign clr_ev_c  = sw.clear      & ~clr_prev;
  assign lap_ev_c  = sw.lap        & ~lap_prev;
  assign load_ev_c = sw.load       & ~load_prev;

  assign tick_c = (state == RUN) && (presc == PRESC_LAST);

  bcd_incrementer u_inc (
    .bcd_in (count),
    .sum_c  (inc_c),
    .wrap_c (wrap_c)
  );

  // Next-state and datapath decode; clear overrides every other event.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    presc_nxt    = presc;
    overflow_nxt = sw.overflow;
    lap_hold_nxt = lap_hold;
    snapshot_nxt = snapshot;

    if (state == RUN) begin
      if (tick_c) begin
        presc_nxt = '0;
        count_nxt = inc_c;
        if (wrap_c) begin
          overflow_nxt = 1'b1;
        end
      end else begin
        presc_nxt = presc + PRESC_W'(1);
      end
    end

    if (clr_ev_c) begin
      state_nxt    = IDLE;
      count_nxt    = '0;
      presc_nxt    = '0;
      overflow_nxt = 1'b0;
      lap_hold_nxt = 1'b0;
    end else begin
      case (state)
        IDLE:    if (ss_ev_c) state_nxt = RUN;
        RUN:     if (ss_ev_c) state_nxt = PAUSE;
        PAUSE:   if (ss_ev_c) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase

      if (load_ev_c && (state != RUN)) begin
        count_nxt    = clamp_bcd(sw.load_value);
        presc_nxt    = '0;
        lap_hold_nxt = 1'b0;
      end

      if (lap_ev_c) begin
        if (lap_hold) begin
          lap_hold_nxt = 1'b0;
        end else if (state == RUN) begin
          snapshot_nxt = count;
          lap_hold_nxt = 1'b1;
        end
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      snapshot    <= '0;
      presc       <= '0;
      lap_hold    <= 1'b0;
      ss_prev     <= 1'b1;
      clr_prev    <= 1'b1;
      lap_prev    <= 1'b1;
      load_prev   <= 1'b1;
      sw.bcd_out  <= '0;
      sw.running  <= 1'b0;
      sw.overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      snapshot    <= snapshot_nxt;
      presc       <= presc_nxt;
      lap_hold    <= lap_hold_nxt;
      ss_prev     <= sw.start_stop;
      clr_prev    <= sw.clear;
      lap_prev    <= sw.lap;
      load_prev   <= sw.load;
      sw.bcd_out  <= lap_hold_nxt ? snapshot_nxt : count_nxt;
      sw.running  <= (state_nxt == RUN);
      sw.overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for the BCD stopwatch with a short prescaler.
module tb_bcd_stopwatch_counter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_stopwatch_counter_if sw_if ();

  bcd_stopwatch_counter #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.load       = 1'b0;
    sw_if.load_value = '0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_bcd", sw_if.bcd_out, 32'h0);
    check("rst_run", 32'(sw_if.running), 32'h0);
    check("rst_ovf", 32'(sw_if.overflow), 32'h0);

    // Held start_stop: one toggle, 4 cycles per count.
    sw_if.start_stop = 1'b1;
    cyc(1);
    check("start_run", 32'(sw_if.running), 32'h1);
    cyc(40);
    check("run40", sw_if.bcd_out, 32'h0000_0010);
    cyc(159);
    check("held_run", 32'(sw_if.running), 32'h1);
    check("held_bcd", sw_if.bcd_out, 32'h0000_0049);
    sw_if.start_stop = 1'b0;
    cyc(1);
    check("roll_50", sw_if.bcd_out, 32'h0000_0050);
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    check("pause_run", 32'(sw_if.running), 32'h0);
    check("pause_bcd", sw_if.bcd_out, 32'h0000_0050);

    // Load 999 in PAUSE then carry across three digits.
    sw_if.load_value = 32'h0000_0999;
    sw_if.load = 1'b1;
    cyc(1);
    sw_if.load = 1'b0;
    check("load_999", sw_if.bcd_out, 32'h0000_0999);
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    cyc(4);
    check("carry_1000", sw_if.bcd_out, 32'h0000_1000);
    check("carry_ovf", 32'(sw_if.overflow), 32'h0);
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    cyc(1);

    // Full wrap sets overflow; clear drops it.
    sw_if.load_value = 32'h9999_9999;
    sw_if.load = 1'b1;
    cyc(1);
    sw_if.load = 1'b0;
    check("load_max", sw_if.bcd_out, 32'h9999_9999);
    cyc(1);
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    cyc(3);
    check("pre_wrap", sw_if.bcd_out, 32'h9999_9999);
    check("pre_wrap_ovf", 32'(sw_if.overflow), 32'h0);
    cyc(1);
    check("wrap_bcd", sw_if.bcd_out, 32'h0);
    check("wrap_ovf", 32'(sw_if.overflow), 32'h1);
    sw_if.clear = 1'b1;
    cyc(1);
    sw_if.clear = 1'b0;
    check("clr_ovf", 32'(sw_if.overflow), 32'h0);
    check("clr_run", 32'(sw_if.running), 32'h0);
    check("clr_bcd", sw_if.bcd_out, 32'h0);
    cyc(1);

    // Lap freeze and release.
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    cyc(20);
    check("lap_pre", sw_if.bcd_out, 32'h0000_0005);
    sw_if.lap = 1'b1;
    cyc(1);
    sw_if.lap = 1'b0;
    cyc(19);
    check("lap_hold20", sw_if.bcd_out, 32'h0000_0005);
    cyc(20);
    check("lap_hold40", sw_if.bcd_out, 32'h0000_0005);
    sw_if.lap = 1'b1;
    cyc(1);
    sw_if.lap = 1'b0;
    check("lap_release", sw_if.bcd_out, 32'h0000_0015);

    // Load in RUN is ignored and counting continues.
    sw_if.load_value = 32'h1234_5678;
    sw_if.load = 1'b1;
    cyc(1);
    sw_if.load = 1'b0;
    check("load_in_run", sw_if.bcd_out, 32'h0000_0015);
    cyc(2);
    check("run_after_load", sw_if.bcd_out, 32'h0000_0016);

    // Clear wins over a simultaneous start_stop.
    sw_if.clear = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.clear = 1'b0;
    sw_if.start_stop = 1'b0;
    check("clr_ss_run", 32'(sw_if.running), 32'h0);
    check("clr_ss_bcd", sw_if.bcd_out, 32'h0);
    cyc(1);

    // Nibble clamp on load in IDLE; lap in IDLE ignored.
    sw_if.load_value = 32'h0000_A0F3;
    sw_if.load = 1'b1;
    cyc(1);
    sw_if.load = 1'b0;
    check("load_clamp", sw_if.bcd_out, 32'h0000_9093);
    sw_if.lap = 1'b1;
    cyc(1);
    sw_if.lap = 1'b0;
    check("lap_idle", sw_if.bcd_out, 32'h0000_9093);
    cyc(1);

    // start_stop on a tick cycle: increment lands and state pauses.
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    cyc(3);
    check("tick_pre", sw_if.bcd_out, 32'h0000_9093);
    sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.start_stop = 1'b0;
    check("tick_ss_bcd", sw_if.bcd_out, 32'h0000_9094);
    check("tick_ss_run", 32'(sw_if.running), 32'h0);
    cyc(1);

    // start_stop held through reset release gives no start event.
    reset = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc(2);
    check("rst2_bcd", sw_if.bcd_out, 32'h0);
    reset = 1'b0;
    cyc(3);
    check("held_rst_run", 32'(sw_if.running), 32'h0);
    sw_if.start_stop = 1'b0;
    cyc(1);
    sw_if.start_stop = 1'b1;
    cyc(1);
    check("after_rst_run", 32'(sw_if.running), 32'h1);
    sw_if.start_stop = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
